// File: rtl/tile_pixel_pipeline_if.sv
// ---------------------------------------------------------------------------
// tile_pixel_pipeline_if
//
// Purpose: groups the beam-position inputs, the tile-map read port and the
// VGA outputs of tile_pixel_pipeline. There is no valid/ready handshake: the
// pipeline accepts one pixel position every clock and produces one rgb/sync
// sample every clock, three cycles later, with no stalls.
//
// Signals:
//   hsync_in, vsync_in   sync from the sync generator
//   display_on           beam inside the visible 640x480 area
//   screen_hpos/vpos     visible x (0..639) / y (0..479)
//   frame_end            one-cycle pulse per frame
//   tile_col/tile_row    tile-map read address (pipeline -> map)
//   tile_id              tile-map data, combinational from tile_col/tile_row
//   hsync_out, vsync_out syncs aligned with rgb
//   rgb                  {R1,G1,B1,R0,G0,B0}
//
// Modports:
//   master - the sync generator / tile map / VGA side
//   slave  - the pixel pipeline
// ---------------------------------------------------------------------------
interface tile_pixel_pipeline_if;
    logic       hsync_in;
    logic       vsync_in;
    logic       display_on;
    logic [9:0] screen_hpos;
    logic [9:0] screen_vpos;
    logic       frame_end;
    logic [3:0] tile_col;
    logic [2:0] tile_row;
    logic [3:0] tile_id;
    logic       hsync_out;
    logic       vsync_out;
    logic [5:0] rgb;

    modport master (
        output hsync_in, vsync_in, display_on, screen_hpos, screen_vpos,
               frame_end, tile_id,
        input  tile_col, tile_row, hsync_out, vsync_out, rgb
    );

    modport slave (
        input  hsync_in, vsync_in, display_on, screen_hpos, screen_vpos,
               frame_end, tile_id,
        output tile_col, tile_row, hsync_out, vsync_out, rgb
    );
endinterface

// File: rtl/tile_pixel_pipeline.sv
// ---------------------------------------------------------------------------
// tile_pixel_pipeline
//
// Purpose: three-stage tile renderer. Stage 1 registers the tile-map address
// and the sub-pixel coordinates, stage 2 captures the tile id returned by the
// map, stage 3 turns the id into a 6-bit colour. Syncs and display_on travel
// alongside so rgb, hsync_out and vsync_out line up, 3 cycles after the
// inputs.
//
// Ports:
//   clk    input  pixel clock, rising edge
//   reset  input  synchronous, active-high
//   bus    tile_pixel_pipeline_if.slave (beam inputs, map port, VGA outputs)
//
// Build option: GRID_LINES_EN - when defined, visible pixels on a 64-pixel
// grid line (hpos[5:0]==0 or vpos[5:0]==0) render as 6'b010101.
//
// No FSM; a 6-bit frame counter drives the blink of tile id 7.
// ---------------------------------------------------------------------------
module tile_pixel_pipeline (
    input  logic                        clk,
    input  logic                        reset,
    tile_pixel_pipeline_if.slave        bus
);

    // Stage 1
    logic [3:0] r_tile_col;
    logic [2:0] r_tile_row;
    logic [2:0] r_s1_x;
    logic [2:0] r_s1_y;
    logic       r_s1_de;
    logic       r_s1_hs;
    logic       r_s1_vs;
    // Stage 2
    logic [3:0] r_s2_id;
    logic [2:0] r_s2_x;
    logic [2:0] r_s2_y;
    logic       r_s2_de;
    logic       r_s2_hs;
    logic       r_s2_vs;
    // Stage 3
    logic [5:0] r_rgb;
    logic       r_hsync_out;
    logic       r_vsync_out;
    logic [5:0] r_frame_cnt;

    logic [7:0] w_bmp_row;
    logic       w_bmp_bit;
    logic [5:0] w_tile_rgb;
    logic [5:0] w_rgb_next;
    logic       w_unused;

`ifdef GRID_LINES_EN
    logic       r_s1_grid;
    logic       r_s2_grid;
`endif

    // Low position bits only matter for the grid overlay; vpos[9] is never
    // needed because the visible area stops at 479.
    assign w_unused = ^{bus.screen_vpos[9], bus.screen_hpos[2:0], bus.screen_vpos[2:0]};

    // 8x8 bitmap rows for ids 1..7; bit x of the returned byte is pixel x.
    function automatic logic [7:0] bitmap_row(input logic [2:0] id, input logic [2:0] y);
        logic [7:0] row;
        row = 8'h00;
        case (id)
            3'd1: row = y[0] ? 8'hAA : 8'h55;                  // checkerboard
            3'd2: row = y[0] ? 8'h00 : 8'hFF;                  // horizontal stripes
            3'd3: row = 8'hF0;                                 // right half
            3'd4: row = (y == 3'd0 || y == 3'd7) ? 8'hFF : 8'h81;  // frame
            3'd5: row = 8'd1 << y;                             // diagonal
            3'd6: row = 8'hFF;                                 // solid
            3'd7: row = (y == 3'd3 || y == 3'd4) ? 8'hFF : 8'h18;  // cross
            default: row = 8'h00;
        endcase
        return row;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tile_col  <= '0;
            r_tile_row  <= '0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_de     <= 1'b0;
            r_s1_hs     <= 1'b1;
            r_s1_vs     <= 1'b1;
            r_s2_id     <= '0;
            r_s2_x      <= '0;
            r_s2_y      <= '0;
            r_s2_de     <= 1'b0;
            r_s2_hs     <= 1'b1;
            r_s2_vs     <= 1'b1;
            r_rgb       <= '0;
            r_hsync_out <= 1'b1;
            r_vsync_out <= 1'b1;
            r_frame_cnt <= '0;    // reset also swallows a coincident frame_end
        end else begin
            r_tile_col  <= bus.screen_hpos[9:6];
            r_tile_row  <= bus.screen_vpos[8:6];
            r_s1_x      <= bus.screen_hpos[5:3];
            r_s1_y      <= bus.screen_vpos[5:3];
            r_s1_de     <= bus.display_on;
            r_s1_hs     <= bus.hsync_in;
            r_s1_vs     <= bus.vsync_in;
            r_s2_id     <= bus.tile_id;
            r_s2_x      <= r_s1_x;
            r_s2_y      <= r_s1_y;
            r_s2_de     <= r_s1_de;
            r_s2_hs     <= r_s1_hs;
            r_s2_vs     <= r_s1_vs;
            r_rgb       <= w_rgb_next;
            r_hsync_out <= r_s2_hs;
            r_vsync_out <= r_s2_vs;
            if (bus.frame_end) begin
                r_frame_cnt <= r_frame_cnt + 6'd1;
            end
        end
    end

`ifdef GRID_LINES_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_grid <= 1'b0;
            r_s2_grid <= 1'b0;
        end else begin
            r_s1_grid <= (bus.screen_hpos[5:0] == 6'd0) || (bus.screen_vpos[5:0] == 6'd0);
            r_s2_grid <= r_s1_grid;
        end
    end
`endif

    always_comb begin
        w_bmp_row  = bitmap_row(r_s2_id[2:0], r_s2_y);
        w_bmp_bit  = w_bmp_row[r_s2_x];
        w_tile_rgb = 6'b000000;
        if (r_s2_id[3]) begin
            w_tile_rgb = {r_s2_id[2:0], 3'b111};
        end else if (r_s2_id == 4'd7 && r_frame_cnt[5]) begin
            w_tile_rgb = 6'b000000;   // blink-off half of the 64-frame cycle
        end else if (w_bmp_bit) begin
            w_tile_rgb = 6'b111111;   // id 0 has an all-zero bitmap row
        end
`ifdef GRID_LINES_EN
        if (r_s2_grid) begin
            w_tile_rgb = 6'b010101;
        end
`endif
        w_rgb_next = r_s2_de ? w_tile_rgb : 6'b000000;
    end

    assign bus.tile_col  = r_tile_col;
    assign bus.tile_row  = r_tile_row;
    assign bus.rgb       = r_rgb;
    assign bus.hsync_out = r_hsync_out;
    assign bus.vsync_out = r_vsync_out;

endmodule

// File: tb/tb_tile_pixel_pipeline.sv
// ---------------------------------------------------------------------------
// tb_tile_pixel_pipeline
//
// Directed bench: each step drives one pixel position, pushes the expected
// {hsync,vsync,rgb} three cycles out and the expected tile address one cycle
// out, then compares whatever the pipeline emits against the queue heads.
// ---------------------------------------------------------------------------
module tb_tile_pixel_pipeline;

    logic clk;
    logic reset;

    tile_pixel_pipeline_if bus ();

    tile_pixel_pipeline dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- tile map model ----------------
    logic [3:0] tile_map [0:7][0:15];
    assign bus.tile_id = tile_map[bus.tile_row][bus.tile_col];

    logic [7:0] bmp [1:7][0:7];

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q [$];
    logic [6:0] tile_q [$];
    int         total;
    int         bad;
    int         fc;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [5:0] model_rgb(input logic [9:0] h, input logic [9:0] v, input logic de);
        logic [3:0] id;
        logic [2:0] x;
        logic [2:0] y;
        logic [7:0] row;
        logic [5:0] c;
        id = tile_map[v[8:6]][h[9:6]];
        x  = h[5:3];
        y  = v[5:3];
        c  = 6'b000000;
        if (id >= 4'd8) begin
            c = {id[2:0], 3'b111};
        end else if (id != 4'd0) begin
            row = bmp[id[2:0]][y];
            if (!(id == 4'd7 && fc >= 32) && row[x]) c = 6'b111111;
        end
`ifdef GRID_LINES_EN
        if (h[5:0] == 6'd0 || v[5:0] == 6'd0) c = 6'b010101;
`endif
        if (!de) c = 6'b000000;
        return c;
    endfunction

    // ---------------- driver ----------------
    task automatic step(input logic rst, input logic [9:0] h, input logic [9:0] v,
                        input logic de, input logic hs, input logic vs, input logic fe);
        logic [7:0] e;
        logic [6:0] t;
        @(posedge clk);
        #1;
        if (exp_q.size() == 3) begin
            e = exp_q.pop_front();
            chk("out", {bus.hsync_out, bus.vsync_out, bus.rgb}, e);
        end
        if (tile_q.size() == 1) begin
            t = tile_q.pop_front();
            chk("tile", {1'b0, bus.tile_row, bus.tile_col}, {1'b0, t});
        end
        reset           = rst;
        bus.screen_hpos = h;
        bus.screen_vpos = v;
        bus.display_on  = de;
        bus.hsync_in    = hs;
        bus.vsync_in    = vs;
        bus.frame_end   = fe;
        if (rst) begin
            exp_q.delete();
            repeat (3) exp_q.push_back(8'b11_000000);
            tile_q.delete();
            tile_q.push_back(7'd0);
            fc = 0;
        end else begin
            exp_q.push_back({hs, vs, model_rgb(h, v, de)});
            tile_q.push_back({v[8:6], h[9:6]});
            if (fe) fc = (fc + 1) % 64;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic pix(input int h, input int v);
        step(1'b0, h[9:0], v[9:0], 1'b1, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic pulse_frames(input int n);
        idle(3);
        repeat (n) step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        total = 0;
        bad   = 0;
        fc    = 0;
        bmp[1] = '{8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA, 8'h55, 8'hAA};
        bmp[2] = '{8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        bmp[3] = '{8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
        bmp[4] = '{8'hFF, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'h81, 8'hFF};
        bmp[5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        bmp[6] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        bmp[7] = '{8'h18, 8'h18, 8'h18, 8'hFF, 8'hFF, 8'h18, 8'h18, 8'h18};
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 16; c++) tile_map[r][c] = 4'd0;
        tile_map[1][2] = 4'd10;
        tile_map[1][1] = 4'd15;
        tile_map[4][5] = 4'd15;
        begin
            logic [3:0] ids [0:9];
            ids = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd15};
            for (int c = 0; c < 10; c++) begin
                tile_map[2][c] = ids[c];
                tile_map[7][c] = ids[9 - c];
                tile_map[3][c] = 4'd7;
            end
        end

        reset           = 1'b1;
        bus.screen_hpos = '0;
        bus.screen_vpos = '0;
        bus.display_on  = 1'b0;
        bus.hsync_in    = 1'b1;
        bus.vsync_in    = 1'b1;
        bus.frame_end   = 1'b0;

        // reset state
        repeat (3) step(1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0);

        // single-cycle hsync pulse, then a vsync pulse
        idle(2);
        step(1'b0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        step(1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(3);

        // address decode and solid colour id 10
        pix(130, 70);
        // id 0 area, and id 15 with display off / on
        pix(10, 10);
        pix(300, 40);
        step(1'b0, 10'd328, 10'd264, 1'b0, 1'b1, 1'b1, 1'b0);
        pix(328, 264);
        // id 15 at hpos=64 (grid line when the overlay is built in)
        pix(64, 100);

        // bitmap and solid ids across row 2 and partial row 7
        for (int i = 0; i < 40; i++) pix($urandom_range(0, 639), $urandom_range(128, 191));
        for (int i = 0; i < 12; i++) pix($urandom_range(0, 639), $urandom_range(448, 479));

        // reset for one cycle in the middle of a line
        for (int i = 0; i < 4; i++) pix($urandom_range(0, 639), $urandom_range(128, 191));
        step(1'b1, 10'd200, 10'd150, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) pix($urandom_range(0, 639), $urandom_range(128, 191));

        // id 7 blink: visible, blanked after 32 frames, visible again after 64
        pix(16, 216);
        pix(0, 192);
        pulse_frames(32);
        pix(16, 216);
        pix(40, 230);
        pulse_frames(31);
        pix(16, 216);
        pulse_frames(1);
        pix(16, 216);
        pix(40, 230);

        // frame_end coinciding with reset must not count
        pulse_frames(32);
        pix(16, 216);
        step(1'b1, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        pix(16, 216);
        pix(104, 224);

        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
